// File: rtl/fdc_pkg.sv
// Shared types and constants for the floppy-controller CPU bus front end.
// Access records flow from the bus decoder, through the pending slot, into the strobe FSM.
package fdc_pkg;

  localparam logic [11:0] FDC_BASE = 12'hFF4;

  typedef enum logic [1:0] {
    ACC_NONE   = 2'd0,
    ACC_CTL_WR = 2'd1,
    ACC_WD_WR  = 2'd2,
    ACC_WD_RD  = 2'd3
  } acc_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } fdc_state_t;

  typedef struct packed {
    acc_type_t  typ;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_rec_t;

endpackage

// File: rtl/fdc_req_fifo1.sv
// One-deep pending slot for accesses that arrive while a strobe window is busy.
// A push into a full slot is dropped and latches OVERRUN until reset; push+pop refills the slot.
module fdc_req_fifo1
  import fdc_pkg::*;
(
  input  logic     CLK,
  input  logic     RESET_N,
  input  logic     PUSH,
  input  acc_rec_t PUSH_REC,
  input  logic     POP,
  output logic     FULL,
  output acc_rec_t POP_REC,
  output logic     OVERRUN
);

  logic accept;

  assign accept = PUSH && (!FULL || POP);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FULL    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (accept) begin
        FULL <= 1'b1;
      end else if (POP) begin
        FULL <= 1'b0;
      end
      if (PUSH && FULL && !POP) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  // Payload is qualified by FULL, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      POP_REC <= PUSH_REC;
    end
  end

endmodule

// File: rtl/fdc_bus_if.sv
// CPU-side bus front end: decodes $FF40-$FF4F and turns single-clock CPU accesses into
// stretched, registered $FF40 latch and WD1793 strobes with stable address/data.
module fdc_bus_if
  import fdc_pkg::*;
#(
  parameter int STRETCH_CLKS = 12,
  parameter int GAP_CLKS     = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DISK_EN,
  input  logic        CPU_ENA,
  input  logic        BUS_VALID,
  input  logic [15:0] ADDR,
  input  logic        RW_N,
  input  logic [7:0]  DATA_IN,
  output logic        FF40_CLK,
  output logic        FF40_ENA,
  output logic        FF40_RD,
  output logic        WD1793_RD,
  output logic        WD1793_WR_CTRL,
  output logic        WD1793_RD_CTRL,
  output logic [1:0]  ADDRESS,
  output logic [7:0]  DATA_OUT,
  output logic        OVERRUN
);

  localparam logic [3:0] ASSERT_LAST = 4'(STRETCH_CLKS - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CLKS - 1);
  localparam logic [3:0] CLK_HALF    = 4'(STRETCH_CLKS / 2);

  logic       hit, sel_wd, sel_ctl;
  logic       capture;
  acc_type_t  cap_typ;
  acc_rec_t   cap_rec;
  logic       unused_addr;

  fdc_state_t state_q, state_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  acc_type_t  typ_q, typ_nxt;
  logic       load;
  acc_rec_t   load_rec;

  logic       pend_push, pend_pop, pend_full;
  acc_rec_t   pend_rec;

  logic       asrt_nxt, ff40_clk_nxt, ff40_ena_nxt, wd_wr_nxt, wd_rd_nxt;

  assign hit         = DISK_EN && (ADDR[15:4] == FDC_BASE);
  assign sel_wd      = ADDR[3];
  assign sel_ctl     = ~ADDR[3];
  assign unused_addr = ADDR[2];

  assign FF40_RD   = BUS_VALID && hit && sel_ctl && RW_N;
  assign WD1793_RD = BUS_VALID && hit && sel_wd && RW_N;

  // A ctl-read is serviced by FF40_RD alone and never reaches the strobe FSM.
  always_comb begin
    cap_typ = ACC_NONE;
    if (CPU_ENA && hit) begin
      if (!RW_N) begin
        cap_typ = sel_wd ? ACC_WD_WR : ACC_CTL_WR;
      end else if (sel_wd) begin
        cap_typ = ACC_WD_RD;
      end
    end
  end

  assign capture = (cap_typ != ACC_NONE);
  assign cap_rec = '{typ: cap_typ, addr: ADDR[1:0], data: DATA_IN};

  fdc_req_fifo1 u_pending (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .PUSH     (pend_push),
    .PUSH_REC (cap_rec),
    .POP      (pend_pop),
    .FULL     (pend_full),
    .POP_REC  (pend_rec),
    .OVERRUN  (OVERRUN)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    load      = 1'b0;
    load_rec  = cap_rec;
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          load      = 1'b1;
          state_nxt = ST_ASSERT;
          cnt_nxt   = 4'd0;
        end
      end
      ST_ASSERT: begin
        pend_push = capture;
        if (cnt_q == ASSERT_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_nxt = 4'd0;
          // Pending goes first; a same-cycle capture takes the slot it frees.
          if (pend_full) begin
            pend_pop  = 1'b1;
            pend_push = capture;
            load      = 1'b1;
            load_rec  = pend_rec;
            state_nxt = ST_ASSERT;
          end else if (capture) begin
            load      = 1'b1;
            state_nxt = ST_ASSERT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          pend_push = capture;
          cnt_nxt   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Strobes are decoded from next-state so the outputs come straight from flops.
  always_comb begin
    typ_nxt      = load ? load_rec.typ : typ_q;
    asrt_nxt     = (state_nxt == ST_ASSERT);
    ff40_ena_nxt = asrt_nxt && (typ_nxt == ACC_CTL_WR);
    ff40_clk_nxt = ff40_ena_nxt && (cnt_nxt < CLK_HALF);
    wd_wr_nxt    = asrt_nxt && (typ_nxt == ACC_WD_WR);
    wd_rd_nxt    = asrt_nxt && (typ_nxt == ACC_WD_RD);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      typ_q          <= ACC_NONE;
      FF40_CLK       <= 1'b0;
      FF40_ENA       <= 1'b0;
      WD1793_WR_CTRL <= 1'b0;
      WD1793_RD_CTRL <= 1'b0;
      ADDRESS        <= 2'd0;
      DATA_OUT       <= 8'd0;
    end else begin
      state_q        <= state_nxt;
      cnt_q          <= cnt_nxt;
      typ_q          <= typ_nxt;
      FF40_CLK       <= ff40_clk_nxt;
      FF40_ENA       <= ff40_ena_nxt;
      WD1793_WR_CTRL <= wd_wr_nxt;
      WD1793_RD_CTRL <= wd_rd_nxt;
      if (load) begin
        ADDRESS  <= load_rec.addr;
        DATA_OUT <= load_rec.data;
      end
    end
  end

endmodule

// File: tb/tb_fdc_bus_if.sv
// Directed bench for fdc_bus_if: strobe windows, pending/overrun, reset and decode enable.
module tb_fdc_bus_if;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DISK_EN;
  logic        CPU_ENA;
  logic        BUS_VALID;
  logic [15:0] ADDR;
  logic        RW_N;
  logic [7:0]  DATA_IN;
  logic        FF40_CLK, FF40_ENA, FF40_RD, WD1793_RD;
  logic        WD1793_WR_CTRL, WD1793_RD_CTRL;
  logic [1:0]  ADDRESS;
  logic [7:0]  DATA_OUT;
  logic        OVERRUN;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  fdc_bus_if #(.STRETCH_CLKS(12), .GAP_CLKS(4)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .DISK_EN        (DISK_EN),
    .CPU_ENA        (CPU_ENA),
    .BUS_VALID      (BUS_VALID),
    .ADDR           (ADDR),
    .RW_N           (RW_N),
    .DATA_IN        (DATA_IN),
    .FF40_CLK       (FF40_CLK),
    .FF40_ENA       (FF40_ENA),
    .FF40_RD        (FF40_RD),
    .WD1793_RD      (WD1793_RD),
    .WD1793_WR_CTRL (WD1793_WR_CTRL),
    .WD1793_RD_CTRL (WD1793_RD_CTRL),
    .ADDRESS        (ADDRESS),
    .DATA_OUT       (DATA_OUT),
    .OVERRUN        (OVERRUN)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return the CPU bus to idle.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      CPU_ENA   = 1'b0;
      BUS_VALID = 1'b0;
    end
  endtask

  task automatic cpu(input logic [15:0] a, input logic rw, input logic [7:0] d);
    ADDR      = a;
    RW_N      = rw;
    DATA_IN   = d;
    BUS_VALID = 1'b1;
    CPU_ENA   = 1'b1;
  endtask

  task automatic chk_strobes(input string tag, input logic [3:0] exp);
    chk(tag, {12'd0, FF40_CLK, FF40_ENA, WD1793_WR_CTRL, WD1793_RD_CTRL}, {12'd0, exp});
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    step(2);
    RESET_N = 1'b1;
    step(1);
  endtask

  initial begin
    RESET_N   = 1'b0;
    DISK_EN   = 1'b1;
    CPU_ENA   = 1'b0;
    BUS_VALID = 1'b0;
    ADDR      = 16'h0000;
    RW_N      = 1'b1;
    DATA_IN   = 8'h00;
    step(2);
    chk_strobes("reset_strobes", 4'b0000);
    chk("reset_address", {14'd0, ADDRESS}, 16'h0000);
    chk("reset_data", {8'd0, DATA_OUT}, 16'h0000);
    chk("reset_overrun", {15'd0, OVERRUN}, 16'h0000);
    RESET_N = 1'b1;
    step(2);

    // $FF40 write: ENA 12 clocks, CLK high for the first 6.
    cpu(16'hFF40, 1'b0, 8'hA9);
    step(1);
    for (int i = 0; i < 12; i++) begin
      chk_strobes("ff40_window", (i < 6) ? 4'b1100 : 4'b0100);
      chk("ff40_data", {8'd0, DATA_OUT}, 16'h00A9);
      step(1);
    end
    chk_strobes("ff40_after", 4'b0000);
    step(4);

    // $FF4B write: WR_CTRL 12 clocks, held through the gap.
    cpu(16'hFF4B, 1'b0, 8'h12);
    step(1);
    for (int i = 0; i < 12; i++) begin
      chk_strobes("wdwr_window", 4'b0010);
      chk("wdwr_addr", {14'd0, ADDRESS}, 16'h0003);
      chk("wdwr_data", {8'd0, DATA_OUT}, 16'h0012);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk_strobes("wdwr_gap", 4'b0000);
      chk("wdwr_gap_addr", {14'd0, ADDRESS}, 16'h0003);
      chk("wdwr_gap_data", {8'd0, DATA_OUT}, 16'h0012);
      step(1);
    end

    // $FF49 read: combinational select plus RD_CTRL window.
    cpu(16'hFF49, 1'b1, 8'h00);
    #1;
    chk("wdrd_comb", {15'd0, WD1793_RD}, 16'h0001);
    chk("wdrd_ff40rd", {15'd0, FF40_RD}, 16'h0000);
    step(1);
    for (int i = 0; i < 12; i++) begin
      chk_strobes("wdrd_window", 4'b0001);
      chk("wdrd_addr", {14'd0, ADDRESS}, 16'h0001);
      step(1);
    end
    chk_strobes("wdrd_after", 4'b0000);
    step(4);

    // $FF40 read: select only, no strobe.
    cpu(16'hFF40, 1'b1, 8'h00);
    #1;
    chk("ctlrd_comb", {15'd0, FF40_RD}, 16'h0001);
    chk("ctlrd_wdrd", {15'd0, WD1793_RD}, 16'h0000);
    step(1);
    for (int i = 0; i < 14; i++) begin
      chk_strobes("ctlrd_nostrobe", 4'b0000);
      step(1);
    end

    // Three wd-writes 2 clocks apart: third dropped.
    cpu(16'hFF48, 1'b0, 8'h01);
    step(2);
    cpu(16'hFF49, 1'b0, 8'h02);
    step(1);
    chk("ovr_second", {15'd0, OVERRUN}, 16'h0000);
    step(1);
    cpu(16'hFF4A, 1'b0, 8'h03);
    step(1);
    chk("ovr_third", {15'd0, OVERRUN}, 16'h0001);
    step(7);
    chk_strobes("ovr_first_last", 4'b0010);
    chk("ovr_first_data", {8'd0, DATA_OUT}, 16'h0001);
    step(1);
    chk_strobes("ovr_first_gap", 4'b0000);
    step(4);
    chk_strobes("ovr_second_start", 4'b0010);
    chk("ovr_second_addr", {14'd0, ADDRESS}, 16'h0001);
    chk("ovr_second_data", {8'd0, DATA_OUT}, 16'h0002);
    step(11);
    chk_strobes("ovr_second_last", 4'b0010);
    step(1);
    chk_strobes("ovr_second_gap", 4'b0000);
    step(4);
    for (int i = 0; i < 12; i++) begin
      chk_strobes("ovr_no_third", 4'b0000);
      step(1);
    end
    chk("ovr_sticky", {15'd0, OVERRUN}, 16'h0001);
    chk("ovr_data_held", {8'd0, DATA_OUT}, 16'h0002);

    // Capture in last GAP cycle with pending full: nothing dropped.
    do_reset();
    chk("lastgap_ovr_clear", {15'd0, OVERRUN}, 16'h0000);
    cpu(16'hFF48, 1'b0, 8'h11);
    step(2);
    cpu(16'hFF49, 1'b0, 8'h22);
    step(14);
    chk_strobes("lastgap_in_gap", 4'b0000);
    cpu(16'hFF4A, 1'b0, 8'h33);
    step(1);
    chk_strobes("lastgap_pend_issue", 4'b0010);
    chk("lastgap_pend_addr", {14'd0, ADDRESS}, 16'h0001);
    chk("lastgap_pend_data", {8'd0, DATA_OUT}, 16'h0022);
    step(16);
    chk_strobes("lastgap_new_issue", 4'b0010);
    chk("lastgap_new_addr", {14'd0, ADDRESS}, 16'h0002);
    chk("lastgap_new_data", {8'd0, DATA_OUT}, 16'h0033);
    chk("lastgap_ovr", {15'd0, OVERRUN}, 16'h0000);
    step(12);
    chk_strobes("lastgap_done", 4'b0000);
    step(4);

    // Async reset at ASSERT cnt=5.
    cpu(16'hFF4B, 1'b0, 8'h5A);
    step(6);
    chk_strobes("rst_pre", 4'b0010);
    RESET_N = 1'b0;
    #1;
    chk_strobes("rst_async_strobes", 4'b0000);
    chk("rst_async_addr", {14'd0, ADDRESS}, 16'h0000);
    chk("rst_async_data", {8'd0, DATA_OUT}, 16'h0000);
    step(2);
    RESET_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk_strobes("rst_no_replay", 4'b0000);
    end

    // DISK_EN=0: no decode, no strobe.
    DISK_EN = 1'b0;
    cpu(16'hFF48, 1'b0, 8'h77);
    #1;
    chk("dis_wdrd", {15'd0, WD1793_RD}, 16'h0000);
    step(1);
    for (int i = 0; i < 14; i++) begin
      chk_strobes("dis_nostrobe", 4'b0000);
      step(1);
    end
    chk("dis_data", {8'd0, DATA_OUT}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdc_bus_if.md
Name: fdc_bus_if

Overview:
- CPU-side bus front end for the floppy controller; sits directly upstream of the four-drive WD1793 wrapper.
- Decodes CoCo cartridge I/O cycles at $FF40-$FF4F.
- Converts each single-clock CPU access into stretched, registered control strobes: the $FF40 latch clock/enable and the WD1793 read/write controls.
- Holds register address and write data stable for the whole strobe window, so the downstream synchronizers and 8.33 MHz enable always see a clean access.

Parameters:
- STRETCH_CLKS, 12, CLK cycles each control strobe stays high (legal 4..15).
- GAP_CLKS, 4, CLK cycles of forced low between consecutive strobes (legal 1..15).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DISK_EN  in  1  decode enable (cartridge slot selected); 0 = ignore all cycles.
- CPU_ENA  in  1  one-CLK pulse marking CPU cycle completion; ADDR/RW_N/DATA_IN valid in this cycle.
- BUS_VALID  in  1  CPU address phase valid (qualifies combinational read selects).
- ADDR  in  16  CPU address.
- RW_N  in  1  1 = read, 0 = write.
- DATA_IN  in  8  CPU write data.
- FF40_CLK  out  1  $FF40 latch clock; downstream latches on its falling edge.
- FF40_ENA  out  1  $FF40 latch enable.
- FF40_RD  out  1  combinational: read of $FF40-$FF47 in progress.
- WD1793_RD  out  1  combinational: read of $FF48-$FF4F in progress.
- WD1793_WR_CTRL  out  1  stretched WD1793 write strobe.
- WD1793_RD_CTRL  out  1  stretched WD1793 read strobe.
- ADDRESS  out  2  latched WD1793 register index (ADDR[1:0]).
- DATA_OUT  out  8  latched write data.
- OVERRUN  out  1  sticky flag: an access was dropped.

Behaviour:
- Decode:
  - hit = DISK_EN & ADDR[15:4]==12'hFF4.
  - ctl = ~ADDR[3] ($FF40-$FF47); wd = ADDR[3] ($FF48-$FF4F).
- Combinational read selects:
  - FF40_RD = BUS_VALID & hit & ctl & RW_N.
  - WD1793_RD = BUS_VALID & hit & wd & RW_N.
- Strobe-generating accesses: ctl-write, wd-write, wd-read. A ctl-read produces no strobe.
- Capture: on a CPU_ENA cycle with a strobe-generating hit, record {type, ADDR[1:0], DATA_IN}.
- FSM states: IDLE, ASSERT, GAP. A 4-bit counter cnt counts within ASSERT and GAP.
- IDLE:
  - Captured access loads ADDRESS/DATA_OUT; next cycle enters ASSERT with cnt=0.
  - Latency: strobe high on the first CLK after the CPU_ENA cycle.
- ASSERT, driven for STRETCH_CLKS cycles:
  - wd-write: WD1793_WR_CTRL=1.
  - wd-read: WD1793_RD_CTRL=1.
  - ctl-write: FF40_ENA=1; FF40_CLK=1 while cnt < STRETCH_CLKS/2, then 0. The falling edge lands mid-window with ENA and DATA_OUT stable.
  - When cnt==STRETCH_CLKS-1, go to GAP with cnt=0.
- GAP:
  - All strobes 0; ADDRESS/DATA_OUT held.
  - When cnt==GAP_CLKS-1: if pending is valid, load it and go to ASSERT. Otherwise go to IDLE.
- Pending buffer (one deep):
  - A captured access in ASSERT/GAP goes to pending if pending is empty.
  - If pending is full, the access is dropped and OVERRUN is set; only reset clears OVERRUN.
- Simultaneous events:
  - In the last GAP cycle, pending is issued. A simultaneous new capture enters the now-freed pending slot, so nothing is dropped.
  - In the last GAP cycle with pending empty, a new capture is issued directly.
- ADDRESS/DATA_OUT change only when an access is loaded into ASSERT, never mid-window.
- Reset (asynchronous, any state):
  - All strobes, ADDRESS, DATA_OUT and OVERRUN go to 0 immediately.
  - FSM goes to IDLE, cnt to 0, pending is cleared.
  - An in-flight access is abandoned, not replayed.
- DISK_EN deasserting mid-window does not truncate an in-flight strobe; it blocks new captures only.

Decomposition:
- Shared package fdc_pkg:
  - access-type enum {ACC_NONE, ACC_CTL_WR, ACC_WD_WR, ACC_WD_RD}.
  - FSM state enum.
  - FDC_BASE = 12'hFF4 constant.
- Access record as a packed struct {type, addr[1:0], data[7:0]} in fdc_pkg.
- One natural sub-module: fdc_req_fifo1, the one-deep pending slot with full/drop/overrun logic.
- Decode and FSM stay in the top.

Test Plan:
- Write $FF40=8'hA9 -> FF40_ENA high 12 clocks starting the CLK after CPU_ENA; FF40_CLK high for the first 6 clocks then low; DATA_OUT=8'hA9 throughout; WR/RD_CTRL stay 0.
- Write $FF4B=8'h12 -> WD1793_WR_CTRL high 12 clocks, ADDRESS=2'b11, DATA_OUT=8'h12, held through 4 GAP clocks.
- Read $FF49 with BUS_VALID=1 -> WD1793_RD=1 combinationally; WD1793_RD_CTRL high 12 clocks; ADDRESS=2'b01. Read $FF40 -> FF40_RD=1 with no strobes.
- Three wd-writes on consecutive CPU_ENA pulses 2 clocks apart -> first issued, second issued after GAP, third dropped; OVERRUN=1 and stays 1.
- Capture in the last GAP cycle with pending full -> pending issued next cycle, new access queued, OVERRUN unchanged (0).
- RESET_N low at ASSERT cnt=5 -> all outputs 0 asynchronously; after release, FSM in IDLE, no strobe reappears. Separately, DISK_EN=0 write to $FF48 -> no response.
